// File: rtl/fir_pkg.sv
// Shared sample types and the lane-select helper used by the FIR lane serializer.
package fir_pkg;

  localparam int SAMPLE_W      = 32;
  localparam int NUM_LANES_MAX = 4;

  typedef logic signed [SAMPLE_W-1:0]        sample_t;
  typedef logic [NUM_LANES_MAX*SAMPLE_W-1:0] block_max_t;

  // Lane 0 sits in the least-significant slot and is the oldest sample of the block.
  function automatic sample_t lane_sel(input block_max_t block, input logic [1:0] idx);
    return block[idx*SAMPLE_W +: SAMPLE_W];
  endfunction

endpackage

// File: rtl/fir_block_fifo.sv
// Synchronous FIFO of whole filter blocks; full/empty are decoded from the stored-block count.
module fir_block_fifo
  import fir_pkg::*;
#(
  parameter  int WIDTH = 3 * SAMPLE_W,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/fir_lane_serializer.sv
// Buffers L-lane FIR output blocks and replays them as a single-lane valid/ready sample stream.
module fir_lane_serializer
  import fir_pkg::*;
#(
  parameter  int L     = 3,
  parameter  int W     = SAMPLE_W,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [L*W-1:0] in_data,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [LW-1:0]  level,
  output logic           overflow,
  input  logic           ovf_clr
);

  localparam int             LCW       = (L > 1) ? $clog2(L) : 1;
  localparam logic [LCW-1:0] LAST_LANE = LCW'(L - 1);

  logic [L*W-1:0] fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           drop;
  logic           take;
  logic           blk_done;
  logic [W-1:0]   lane_data;

  logic [LCW-1:0] lane_cnt_q, lane_cnt_d;
  logic           overflow_q, overflow_d;

  // in_ready comes only from registered FIFO state, so a full FIFO refuses even during a release.
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign drop      = in_valid && !in_ready;
  assign take      = out_valid && out_ready;
  assign blk_done  = take && (lane_cnt_q == LAST_LANE);

  fir_block_fifo #(
    .WIDTH (L * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (blk_done),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  generate
    if (W == SAMPLE_W && L <= NUM_LANES_MAX) begin : g_pkg_sel
      block_max_t blk_pad;
      assign blk_pad   = block_max_t'(fifo_rdata);
      assign lane_data = lane_sel(blk_pad, 2'(lane_cnt_q));
    end else begin : g_arr_sel
      logic [W-1:0] lanes [L];
      for (genvar gi = 0; gi < L; gi++) begin : g_lane
        assign lanes[gi] = fifo_rdata[gi*W +: W];
      end
      assign lane_data = lanes[lane_cnt_q];
    end
  endgenerate

  // Gating with out_valid keeps unreset storage off the output while empty.
  assign out_data = out_valid ? lane_data : '0;
  assign out_last = out_valid && (lane_cnt_q == LAST_LANE);

  always_comb begin
    lane_cnt_d = lane_cnt_q;
    if (take) begin
      lane_cnt_d = blk_done ? '0 : lane_cnt_q + 1'b1;
    end
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_lane_serializer.sv
// Directed bench for fir_lane_serializer: ordering, overflow, wrap, stalls and asynchronous reset.
module tb_fir_lane_serializer;

  localparam int L     = 3;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [L*W-1:0] in_data = '0;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [LW-1:0]  level;
  logic           overflow;
  logic           ovf_clr = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_q[$];

  fir_lane_serializer #(.L(L), .W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [L*W-1:0] blk3(input int y1, input int y2, input int y3);
    return {y3, y2, y1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill4(input int base);
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1;
      in_data  = blk3(base + 3*b, base + 3*b + 1, base + 3*b + 2);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++;
    if ({out_valid, out_last, in_ready, overflow, level} !== 7'b0010_000)
      $display("FAIL reset_state: got v=%0b l=%0b rdy=%0b ovf=%0b lvl=%0d want 0 0 1 0 0",
               out_valid, out_last, in_ready, overflow, level);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", out_data);
    else pass_cnt++;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_block();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = blk3(10, 20, 30);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({out_valid, out_last, out_data} !== {1'b1, (i == 2), 32'(10 * (i + 1))})
        $display("FAIL single_lane%0d: got v=%0b last=%0b data=%0d want 1 %0b %0d",
                 i, out_valid, out_last, out_data, (i == 2), 10 * (i + 1));
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({out_valid, level} !== 4'b0_000)
      $display("FAIL single_empty: got v=%0b lvl=%0d want 0 0", out_valid, level);
    else pass_cnt++;
  endtask

  task automatic test_fill_overflow();
    fill4(1);
    total_cnt++;
    if ({level, in_ready, overflow} !== {3'd4, 1'b0, 1'b0})
      $display("FAIL full_state: got lvl=%0d rdy=%0b ovf=%0b want 4 0 0", level, in_ready, overflow);
    else pass_cnt++;
    in_valid = 1'b1;
    in_data  = blk3(100, 101, 102);
    step();
    in_valid = 1'b0;
    total_cnt++;
    if ({level, overflow} !== {3'd4, 1'b1})
      $display("FAIL drop_state: got lvl=%0d ovf=%0b want 4 1", level, overflow);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      total_cnt++;
      if ({out_valid, out_data} !== {1'b1, 32'(i)})
        $display("FAIL drain_sample%0d: got v=%0b data=%0d want 1 %0d", i, out_valid, out_data, i);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({out_valid, level, overflow} !== {1'b0, 3'd0, 1'b1})
      $display("FAIL drain_done: got v=%0b lvl=%0d ovf=%0b want 0 0 1", out_valid, level, overflow);
    else pass_cnt++;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %0b want 0", overflow);
    else pass_cnt++;
  endtask

  task automatic test_full_release();
    int exp_seq[12];
    fill4(200);
    out_ready = 1'b1;
    step();
    step();
    total_cnt++;
    if ({out_last, out_data, level, in_ready} !== {1'b1, 32'd202, 3'd4, 1'b0})
      $display("FAIL release_pre: got last=%0b data=%0d lvl=%0d rdy=%0b want 1 202 4 0",
               out_last, out_data, level, in_ready);
    else pass_cnt++;
    // Offer while full in the release cycle, with ovf_clr also asserted: the drop must win.
    in_valid = 1'b1;
    in_data  = blk3(900, 901, 902);
    ovf_clr  = 1'b1;
    step();
    ovf_clr   = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if ({overflow, level, in_ready} !== {1'b1, 3'd3, 1'b1})
      $display("FAIL release_refuse: got ovf=%0b lvl=%0d rdy=%0b want 1 3 1", overflow, level, in_ready);
    else pass_cnt++;
    in_data = blk3(300, 301, 302);
    step();
    in_valid = 1'b0;
    total_cnt++;
    if ({level, overflow} !== {3'd4, 1'b1})
      $display("FAIL release_next_push: got lvl=%0d ovf=%0b want 4 1", level, overflow);
    else pass_cnt++;
    for (int i = 0; i < 9; i++) exp_seq[i] = 203 + i;
    for (int i = 0; i < 3; i++) exp_seq[9 + i] = 300 + i;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      total_cnt++;
      if ({out_valid, out_data} !== {1'b1, 32'(exp_seq[i])})
        $display("FAIL release_drain%0d: got v=%0b data=%0d want 1 %0d", i, out_valid, out_data, exp_seq[i]);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({out_valid, level} !== 4'b0_000)
      $display("FAIL release_empty: got v=%0b lvl=%0d want 0 0", out_valid, level);
    else pass_cnt++;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
  endtask

  task automatic test_ramp();
    int nxt_out   = 0;
    int k         = 0;
    int max_level = 0;
    int errs      = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 3334 * 3 + 6; c++) begin
      if (out_valid) begin
        total_cnt++;
        if (out_data !== 32'(nxt_out)) begin
          errs++;
          if (errs <= 5) $display("FAIL ramp_sample%0d: got %0d want %0d", nxt_out, out_data, nxt_out);
        end else pass_cnt++;
        nxt_out++;
      end
      if (int'(level) > max_level) max_level = int'(level);
      if ((c % 3 == 0) && (k < 3334)) begin
        in_valid = 1'b1;
        in_data  = blk3(3*k, 3*k + 1, 3*k + 2);
        k++;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (nxt_out !== 10002) $display("FAIL ramp_count: got %0d want 10002", nxt_out);
    else pass_cnt++;
    total_cnt++;
    if (max_level !== 1) $display("FAIL ramp_max_level: got %0d want 1", max_level);
    else pass_cnt++;
    total_cnt++;
    if ({overflow, out_valid} !== 2'b00)
      $display("FAIL ramp_end: got ovf=%0b v=%0b want 0 0", overflow, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_random_ready();
    int       sent    = 0;
    int       cyc     = 0;
    logic     stalled = 1'b0;
    logic [W-1:0] held = '0;
    int       e;
    exp_q.delete();
    while ((sent < 12 || exp_q.size() != 0) && cyc < 2000) begin
      if (stalled) begin
        total_cnt++;
        if ({out_valid, out_data} !== {1'b1, held})
          $display("FAIL stall_hold: got v=%0b data=%h want 1 %h", out_valid, out_data, held);
        else pass_cnt++;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_extra: got data=%h want no sample", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== 32'(e)) $display("FAIL rand_sample: got %h want %h", out_data, e);
          else pass_cnt++;
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (in_ready && sent < 12 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        if (sent % 2 == 0) begin
          in_data = blk3(int'(32'h8000_0000), int'(32'h7FFF_FFFF), sent);
          exp_q.push_back(int'(32'h8000_0000));
          exp_q.push_back(int'(32'h7FFF_FFFF));
          exp_q.push_back(sent);
        end else begin
          in_data = blk3(sent, int'(32'h7FFF_FFFF), int'(32'h8000_0000));
          exp_q.push_back(sent);
          exp_q.push_back(int'(32'h7FFF_FFFF));
          exp_q.push_back(int'(32'h8000_0000));
        end
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (sent !== 12 || exp_q.size() !== 0)
      $display("FAIL rand_complete: got sent=%0d pending=%0d want 12 0", sent, exp_q.size());
    else pass_cnt++;
    total_cnt++;
    if ({out_valid, level, overflow} !== {1'b0, 3'd0, 1'b0})
      $display("FAIL rand_end: got v=%0b lvl=%0d ovf=%0b want 0 0 0", out_valid, level, overflow);
    else pass_cnt++;
  endtask

  task automatic test_reset_midblock();
    fill4(1);
    in_valid = 1'b1;
    in_data  = blk3(50, 51, 52);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    total_cnt++;
    if ({out_last, out_data, overflow} !== {1'b1, 32'd3, 1'b1})
      $display("FAIL mid_pre: got last=%0b data=%0d ovf=%0b want 1 3 1", out_last, out_data, overflow);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, out_last, in_ready, overflow, level} !== 7'b0010_000)
      $display("FAIL mid_async_reset: got v=%0b l=%0b rdy=%0b ovf=%0b lvl=%0d want 0 0 1 0 0",
               out_valid, out_last, in_ready, overflow, level);
    else pass_cnt++;
    step();
    rst = 1'b0;
    step();
    in_valid = 1'b1;
    in_data  = blk3(4, 5, 6);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({out_valid, out_last, out_data} !== {1'b1, (i == 2), 32'(4 + i)})
        $display("FAIL post_reset_lane%0d: got v=%0b last=%0b data=%0d want 1 %0b %0d",
                 i, out_valid, out_last, out_data, (i == 2), 4 + i);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({out_valid, level} !== 4'b0_000)
      $display("FAIL post_reset_empty: got v=%0b lvl=%0d want 0 0", out_valid, level);
    else pass_cnt++;
    fill4(60);
    in_valid = 1'b1;
    in_data  = blk3(70, 71, 72);
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_reset_set: got %0b want 1", overflow);
    else pass_cnt++;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    total_cnt++;
    if ({overflow, level} !== {1'b0, 3'd4})
      $display("FAIL ovf_clr_edge: got ovf=%0b lvl=%0d want 0 4", overflow, level);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_fill_overflow();
    test_full_release();
    test_ramp();
    test_random_ready();
    test_reset_midblock();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fir_lane_serializer.md
Name: fir_lane_serializer

Overview:
- Downstream of the L-lane parallel FIR filters (the L=2 and L=3 variants, with or without pipelining).
- Accepts one block of L filter outputs per cycle (y1..yL). Buffers the blocks in a small FIFO.
- Emits the samples as a single-lane stream, in time order, with a valid/ready handshake.
- Converts the parallel filter's block rate back to a serial sample rate for downstream consumers (DAC model, checker, output DMA).

Parameters:
- L, 3, number of parallel lanes per block (1..4).
- W, 32, signed sample width in bits.
- DEPTH, 4, FIFO depth in blocks; must be a power of 2, at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  block present on in_data; driven by the filter's valid path
- in_data  input  L*W  packed block; bits [W-1:0] = lane 0 = y1 (oldest sample); lane k at [k*W+W-1:k*W]
- in_ready  output  1  FIFO can accept a block this cycle
- out_valid  output  1  out_data holds a valid sample
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  W  current serial sample (signed)
- out_last  output  1  out_data is lane L-1 of its block
- level  output  $clog2(DEPTH+1)  number of blocks currently stored, including a partially drained block
- overflow  output  1  sticky: a block was offered while full and was dropped
- ovf_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync release) drives the following values:
  - write/read pointers = 0, level = 0, lane_cnt = 0
  - overflow = 0, out_valid = 0, out_last = 0, in_ready = 1
  - out_data = 0; FIFO storage is not reset.
- Push condition: in_valid && in_ready.
  - Stores in_data at wr_ptr; wr_ptr increments modulo DEPTH.
- in_ready:
  - in_ready = (level != DEPTH). It depends only on registered state, with no combinational path from out_ready.
  - Consequence: a push is refused while full, even when a pop completes in the same cycle.
- Drop rule: in_valid && !in_ready sets overflow on that edge, and the block is discarded.
  - The filter cannot stall, so there is no backpressure beyond this flag.
- overflow:
  - Holds until ovf_clr.
  - If ovf_clr and a new drop happen in the same cycle, the set wins: overflow = 1.
- out_valid = (level != 0).
- out_data = lane[lane_cnt] of the entry at rd_ptr. out_last = out_valid && (lane_cnt == L-1).
- Pop on out_valid && out_ready:
  - if lane_cnt < L-1: lane_cnt increments.
  - else: lane_cnt = 0, rd_ptr increments modulo DEPTH, and the block is released.
- level update:
  - +1 on a push.
  - -1 on a block release (last lane popped).
  - unchanged when both happen in the same cycle.
- Latency: a block pushed at edge N gives out_valid = 1 in the cycle after edge N (lane 0 visible). No fall-through in the same cycle.
- Throughput:
  - Output: 1 sample per cycle while out_ready = 1.
  - Sustained input: 1 block per L cycles. Bursts of up to DEPTH blocks are absorbed losslessly.
- out_ready is ignored while out_valid = 0.
- out_valid, once high, stays high until the sample is taken.
- Wrap-around: pointers wrap modulo DEPTH with no gap. Full vs empty is distinguished only by level.
- Reset mid-block: partial drain state is lost, lane_cnt returns to 0, and all buffered blocks are discarded.
- Arithmetic: samples are passed through bit-exact, with no sign extension or rounding.

Decomposition:
- fir_pkg holds the following:
  - SAMPLE_W = 32 constant and typedef sample_t (logic signed [SAMPLE_W-1:0]).
  - NUM_LANES_MAX = 4.
  - Function lane_sel(block, idx), returning sample_t.
- Sub-module fir_block_fifo: synchronous FIFO of L*W-bit entries.
  - Parameter: DEPTH.
  - Ports: push, pop, wdata, rdata, level, full, empty.
  - fir_lane_serializer owns lane_cnt, the handshake, and the overflow logic around it.

Test Plan:
1. Reset, then a single block in_data = {30,20,10} with out_ready = 1.
   - Expect out_valid from the next cycle.
   - out_data sequence 10, 20, 30 on consecutive cycles; out_last only with 30.
   - Then level = 0 and out_valid = 0.
2. out_ready = 0, push 4 blocks (values 1..12).
   - Expect level = 4 and in_ready = 0.
   - A 5th block sets overflow = 1 and level stays 4.
   - After draining, the output is exactly 1..12 and the dropped block never appears.
3. Full FIFO, offer a block in the same cycle a block release occurs.
   - The block is refused and overflow = 1; level goes 4 -> 3.
   - The next push is accepted.
4. Continuous in_valid every 3rd cycle with a ramp input, out_ready = 1 for 10000 samples.
   - Expect the output to match the ramp exactly.
   - overflow = 0; level never exceeds 1.
5. out_ready toggling randomly at 50%, lanes carrying 32'sh8000_0000 and 32'sh7FFF_FFFF.
   - Expect values preserved bit-exact and in order.
   - out_data stays stable while out_valid && !out_ready.
6. Assert rst after lane 1 of a block has been taken.
   - Expect out_valid = 0, level = 0, overflow = 0 immediately (async).
   - After release, a new block {6,5,4} outputs 4, 5, 6.
   - ovf_clr clears a previously set overflow on the next edge.
